// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one byte-level SPI shift engine between two requesters (an I/O-port
// host interface and an autonomous flash fetcher). The engine is granted one
// whole transaction at a time. This block owns both chip selects and keeps all
// of them high for at least CS_GAP+1 clocks between transactions. A granted
// requester that issues no byte for IDLE_TIMEOUT clocks loses its grant.
//
// Configuration macro:
//   SPI_ARB_FIXED_PRIO_EN  defined   : requester 0 always wins simultaneous
//                                      requests; no round-robin pointer.
//                          undefined : round robin, the requester not served
//                                      last wins a tie (requester 0 after reset).
//
// Ports:
//   clk_i        system clock, all logic on posedge
//   rst_i        asynchronous active-high reset (engine shares it)
//   req_i[1:0]   per-requester request level, held for the whole transaction
//   gnt_o[1:0]   one-hot grant, or 0
//   bv_i[1:0]    per-requester byte valid (only the granted bit is sampled)
//   blast_i[1:0] qualifies bv_i: this byte ends the transaction
//   btx0_i       requester 0 transmit byte
//   btx1_i       requester 1 transmit byte
//   bdone_o[1:0] one-clock pulse to the granted requester on byte completion
//   brx_o        received byte, valid with bdone_o, held otherwise
//   eng_start_o  one-clock start pulse to the engine
//   eng_tx_o     byte to the engine, stable from start until done
//   eng_done_i   one-clock pulse from the engine: byte shifted
//   eng_rx_i     engine received byte, valid with eng_done_i
//   cs_n_o[1:0]  active-low chip select per requester
//   tmo_o        one-clock pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int unsigned CS_GAP       = 4,
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    input  logic [1:0] bv_i,
    input  logic [1:0] blast_i,
    input  logic [7:0] btx0_i,
    input  logic [7:0] btx1_i,
    output logic [1:0] bdone_o,
    output logic [7:0] brx_o,
    output logic       eng_start_o,
    output logic [7:0] eng_tx_o,
    input  logic       eng_done_i,
    input  logic [7:0] eng_rx_i,
    output logic [1:0] cs_n_o,
    output logic       tmo_o
);

    localparam int unsigned IDLE_CNT_W = 8;
    localparam int unsigned GAP_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t                state_q;
    logic [1:0]            gnt_q;
    logic                  gidx_q;
    logic [1:0]            cs_n_q;
    logic [1:0]            bdone_q;
    logic [7:0]            brx_q;
    logic                  eng_start_q;
    logic [7:0]            eng_tx_q;
    logic                  tmo_q;
    logic                  last_byte_q;
    logic [IDLE_CNT_W-1:0] idle_cnt_q;
    logic [GAP_CNT_W-1:0]  gap_cnt_q;
`ifndef SPI_ARB_FIXED_PRIO_EN
    logic                  rr_last_q;   // index of the requester served last
`endif

    logic                  win_idx_d;
    logic                  g_req;
    logic                  g_bv;
    logic                  g_blast;
    logic [7:0]            g_btx;

    // Arbitration winner index; only meaningful when some request is high.
    always_comb begin
        win_idx_d = ~req_i[0];
`ifndef SPI_ARB_FIXED_PRIO_EN
        if (req_i == 2'b11) begin
            win_idx_d = ~rr_last_q;
        end
`endif
    end

    // Signals of the currently granted requester.
    always_comb begin
        g_req   = req_i[gidx_q];
        g_bv    = bv_i[gidx_q];
        g_blast = blast_i[gidx_q];
        g_btx   = gidx_q ? btx1_i : btx0_i;
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            gidx_q      <= 1'b0;
            cs_n_q      <= 2'b11;
            bdone_q     <= 2'b00;
            brx_q       <= 8'h00;
            eng_start_q <= 1'b0;
            eng_tx_q    <= 8'h00;
            tmo_q       <= 1'b0;
            last_byte_q <= 1'b0;
            idle_cnt_q  <= '0;
            gap_cnt_q   <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_last_q   <= 1'b1;
`endif
        end else begin
            bdone_q     <= 2'b00;
            eng_start_q <= 1'b0;
            tmo_q       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        gidx_q     <= win_idx_d;
                        gnt_q      <= {win_idx_d, ~win_idx_d};
                        cs_n_q     <= {~win_idx_d, win_idx_d};
                        idle_cnt_q <= '0;
                        state_q    <= ST_GRANTED;
                    end
                end

                ST_GRANTED: begin
                    if (g_bv) begin
                        eng_tx_q    <= g_btx;
                        eng_start_q <= 1'b1;
                        last_byte_q <= g_blast;
                        state_q     <= ST_BUSY;
                    end else if (!g_req) begin
                        gnt_q     <= 2'b00;
                        cs_n_q    <= 2'b11;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end else if (idle_cnt_q >= IDLE_CNT_W'(IDLE_TIMEOUT - 1)) begin
                        tmo_q     <= 1'b1;
                        gnt_q     <= 2'b00;
                        cs_n_q    <= 2'b11;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_q <= idle_cnt_q + IDLE_CNT_W'(1);
                    end
                end

                ST_BUSY: begin
                    // A request dropped mid-byte ends the transaction after this byte.
                    if (!g_req) begin
                        last_byte_q <= 1'b1;
                    end
                    if (eng_done_i) begin
                        brx_q   <= eng_rx_i;
                        bdone_q <= gnt_q;
                        if (last_byte_q || !g_req) begin
                            gnt_q     <= 2'b00;
                            cs_n_q    <= 2'b11;
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end else begin
                            idle_cnt_q <= '0;
                            state_q    <= ST_GRANTED;
                        end
                    end
                end

                ST_GAP: begin
`ifndef SPI_ARB_FIXED_PRIO_EN
                    rr_last_q <= gidx_q;
`endif
                    if (gap_cnt_q >= GAP_CNT_W'(CS_GAP - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign cs_n_o      = cs_n_q;
    assign bdone_o     = bdone_q;
    assign brx_o       = brx_q;
    assign eng_start_o = eng_start_q;
    assign eng_tx_o    = eng_tx_q;
    assign tmo_o       = tmo_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
//
// Directed bench for spi_bus_arbiter (CS_GAP=4, IDLE_TIMEOUT=8) with a small
// SPI engine model that answers each start after a programmable latency.
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] bv;
    logic [1:0] blast;
    logic [7:0] btx0;
    logic [7:0] btx1;
    logic       eng_done;
    logic [7:0] eng_rx;

    logic [1:0] gnt_o;
    logic [1:0] bdone_o;
    logic [7:0] brx_o;
    logic       eng_start_o;
    logic [7:0] eng_tx_o;
    logic [1:0] cs_n_o;
    logic       tmo_o;

    int errors  = 0;
    int checks  = 0;

    // Engine model state and bus monitors
    int         eng_lat    = 17;
    logic [7:0] eng_rx_val = 8'h00;
    int         eng_cnt    = 0;
    bit         eng_busy   = 1'b0;
    int         n_start    = 0;
    int         bad_cs     = 0;
    int         bad_gnt    = 0;

    spi_bus_arbiter #(
        .CS_GAP       (4),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .bv_i        (bv),
        .blast_i     (blast),
        .btx0_i      (btx0),
        .btx1_i      (btx1),
        .bdone_o     (bdone_o),
        .brx_o       (brx_o),
        .eng_start_o (eng_start_o),
        .eng_tx_o    (eng_tx_o),
        .eng_done_i  (eng_done),
        .eng_rx_i    (eng_rx),
        .cs_n_o      (cs_n_o),
        .tmo_o       (tmo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: acts 1 time unit after each rising edge.
    initial begin
        eng_done = 1'b0;
        eng_rx   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (cs_n_o == 2'b00) bad_cs++;
            if (gnt_o == 2'b11) bad_gnt++;
            if (eng_start_o) n_start++;
            if (rst) begin
                eng_busy = 1'b0;
            end else if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_rx   = eng_rx_val;
                    eng_busy = 1'b0;
                end
            end else if (eng_start_o) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance falling edges until the selected event is seen or budget expires.
    // sel: 0 = bdone, 1 = grant, 2 = tmo
    task automatic wait_ev(input int sel, input int budget, output int cyc);
        bit hit;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            case (sel)
                0:       hit = (bdone_o != 2'b00);
                1:       hit = (gnt_o != 2'b00);
                default: hit = tmo_o;
            endcase
        end while (!hit && cyc < budget);
    endtask

    initial begin
        int         cyc;
        int         cs_hi;
        int         s0;
        logic [1:0] eg;
        logic [7:0] etx;

        rst   = 1'b1;
        req   = 2'b00;
        bv    = 2'b00;
        blast = 2'b00;
        btx0  = 8'h00;
        btx1  = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'(gnt_o),       32'h0);
        chk("rst_cs_n",  32'(cs_n_o),      32'h3);
        chk("rst_start", 32'(eng_start_o), 32'h0);
        chk("rst_tx",    32'(eng_tx_o),    32'h0);
        chk("rst_brx",   32'(brx_o),       32'h0);
        chk("rst_bdone", 32'(bdone_o),     32'h0);
        chk("rst_tmo",   32'(tmo_o),       32'h0);
        rst = 1'b0;

        // Single requester, one-byte transaction
        @(negedge clk);
        eng_lat    = 17;
        eng_rx_val = 8'h3C;
        req   = 2'b01;
        bv    = 2'b01;
        blast = 2'b01;
        btx0  = 8'hA5;
        @(negedge clk);
        chk("s_gnt",   32'(gnt_o),       32'h1);
        chk("s_cs_n",  32'(cs_n_o),      32'h2);
        chk("s_nostart", 32'(eng_start_o), 32'h0);
        @(negedge clk);
        chk("s_start", 32'(eng_start_o), 32'h1);
        chk("s_tx",    32'(eng_tx_o),    32'hA5);
        bv    = 2'b00;
        blast = 2'b00;
        wait_ev(0, 40, cyc);
        chk("s_bdone",   32'(bdone_o), 32'h1);
        chk("s_brx",     32'(brx_o),   32'h3C);
        chk("s_gap_gnt", 32'(gnt_o),   32'h0);
        chk("s_nstart",  32'(n_start), 32'h1);
        cs_hi = 0;
        while (cs_n_o == 2'b11 && cs_hi < 20) begin
            cs_hi++;
            @(negedge clk);
        end
        chk("s_cs_high_clocks", 32'(cs_hi),  32'd5);
        chk("s_regrant",        32'(gnt_o),  32'h1);
        chk("s_brx_hold",       32'(brx_o),  32'h3C);
        chk("s_bdone_pulse",    32'(bdone_o), 32'h0);
        req = 2'b00;
        repeat (6) @(negedge clk);
        chk("s_idle_cs", 32'(cs_n_o), 32'h3);

        // Simultaneous requests, two-byte transactions (fresh reset)
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        eng_lat = 3;
        req     = 2'b11;
        for (int t = 0; t < 4; t++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            eg = 2'b01;
`else
            eg = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
            wait_ev(1, 20, cyc);
            chk("m_gnt", 32'(gnt_o), 32'(eg));
            btx0       = 8'(8'h10 + t);
            btx1       = 8'(8'h20 + t);
            etx        = (eg == 2'b10) ? btx1 : btx0;
            eng_rx_val = 8'(8'h40 + t);
            bv         = 2'b11;
            blast      = 2'b00;
            @(negedge clk);
            chk("m_start1", 32'(eng_start_o), 32'h1);
            chk("m_tx1",    32'(eng_tx_o),    32'(etx));
            bv = 2'b00;
            wait_ev(0, 20, cyc);
            chk("m_bdone1", 32'(bdone_o), 32'(eg));
            chk("m_brx1",   32'(brx_o),   32'(8'h40 + t));
            btx0       = 8'(8'h50 + t);
            btx1       = 8'(8'h60 + t);
            etx        = (eg == 2'b10) ? btx1 : btx0;
            eng_rx_val = 8'(8'h70 + t);
            bv         = eg;
            blast      = eg;
            @(negedge clk);
            chk("m_start2", 32'(eng_start_o), 32'h1);
            chk("m_tx2",    32'(eng_tx_o),    32'(etx));
            bv    = 2'b00;
            blast = 2'b00;
            wait_ev(0, 20, cyc);
            chk("m_bdone2", 32'(bdone_o), 32'(eg));
            chk("m_brx2",   32'(brx_o),   32'(8'h70 + t));
            chk("m_gap",    32'(gnt_o),   32'h0);
        end
        req = 2'b00;
        repeat (6) @(negedge clk);

        // Idle timeout on requester 1
        req = 2'b10;
        @(negedge clk);
        chk("t_gnt",  32'(gnt_o),  32'h2);
        chk("t_cs_n", 32'(cs_n_o), 32'h1);
        wait_ev(2, 20, cyc);
        chk("t_tmo",       32'(tmo_o),  32'h1);
        chk("t_tmo_delay", 32'(cyc),    32'd8);
        chk("t_gnt_off",   32'(gnt_o),  32'h0);
        chk("t_cs_off",    32'(cs_n_o), 32'h3);
        @(negedge clk);
        chk("t_tmo_pulse", 32'(tmo_o), 32'h0);
        wait_ev(1, 20, cyc);
        chk("t_regrant", 32'(gnt_o), 32'h2);
        req = 2'b00;
        repeat (6) @(negedge clk);

        // Request drops while a byte is in flight
        eng_lat    = 6;
        eng_rx_val = 8'hC3;
        req        = 2'b01;
        wait_ev(1, 5, cyc);
        chk("d_gnt", 32'(gnt_o), 32'h1);
        s0    = n_start;
        btx0  = 8'h5A;
        bv    = 2'b01;
        blast = 2'b00;
        @(negedge clk);
        chk("d_start", 32'(eng_start_o), 32'h1);
        bv  = 2'b00;
        req = 2'b00;
        wait_ev(0, 20, cyc);
        chk("d_bdone", 32'(bdone_o), 32'h1);
        chk("d_brx",   32'(brx_o),   32'hC3);
        chk("d_gap",   32'(gnt_o),   32'h0);
        chk("d_cs",    32'(cs_n_o),  32'h3);
        repeat (8) @(negedge clk);
        chk("d_one_start", 32'(n_start - s0), 32'h1);

        // Asynchronous reset during a byte; pointer would otherwise favour 1
        eng_lat    = 17;
        eng_rx_val = 8'h99;
        req        = 2'b10;
        wait_ev(1, 5, cyc);
        chk("r_gnt", 32'(gnt_o), 32'h2);
        btx1  = 8'hE7;
        bv    = 2'b10;
        blast = 2'b10;
        @(negedge clk);
        chk("r_start", 32'(eng_start_o), 32'h1);
        bv    = 2'b00;
        blast = 2'b00;
        repeat (3) @(negedge clk);
        chk("r_busy_cs", 32'(cs_n_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async_cs",    32'(cs_n_o),      32'h3);
        chk("r_async_gnt",   32'(gnt_o),       32'h0);
        chk("r_async_start", 32'(eng_start_o), 32'h0);
        chk("r_async_tx",    32'(eng_tx_o),    32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        chk("r_first_gnt", 32'(gnt_o), 32'h1);
        req = 2'b00;
        repeat (6) @(negedge clk);

        chk("cs_never_both_low", 32'(bad_cs),  32'h0);
        chk("gnt_one_hot",       32'(bad_gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
